// File: rtl/ysyx_bus_rd_arb.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_bus_rd_arb
// Purpose  : Read-channel arbiter/sequencer sharing one AXI4 AR/R master port
//            between the IFU fetch path and the LSU load path. Only one read
//            is outstanding at a time. LSU has priority, and a starvation
//            guard forces an IFU win after STARVE_MAX consecutive LSU grants
//            made while IFU was waiting. LSU loads killed by flush_pipeline
//            are drained silently.
// Ports    : clock/reset         - clock, asynchronous active-high reset
//            flush_pipeline      - kills the in-flight LSU load
//            ifu_* / out_ifu_*   - IFU request (addr, len) and response
//            lsu_* / out_lsu_*   - LSU request (addr, size) and response
//            io_master_*         - AXI4 AR/R master channels
//            out_rresp_err       - pulse on an accepted beat with rresp != 0
//            out_busy            - transaction in progress
//            out_perf_*          - grant counters (0 unless perf build)
// Options  : YSYX_BUS_RD_ARB_PERF_EN enables the performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_bus_rd_arb #(
   parameter int XLEN       = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            flush_pipeline,
   input  logic            ifu_arvalid,
   input  logic [XLEN-1:0] ifu_araddr,
   input  logic [7:0]      ifu_arlen,
   output logic            out_ifu_arready,
   output logic [XLEN-1:0] out_ifu_rdata,
   output logic            out_ifu_rvalid,
   output logic            out_ifu_rlast,
   input  logic            lsu_arvalid,
   input  logic [XLEN-1:0] lsu_araddr,
   input  logic [2:0]      lsu_arsize,
   output logic            out_lsu_arready,
   output logic [XLEN-1:0] out_lsu_rdata,
   output logic            out_lsu_rvalid,
   output logic [XLEN-1:0] io_master_araddr,
   output logic            io_master_arvalid,
   input  logic            io_master_arready,
   output logic [7:0]      io_master_arlen,
   output logic [2:0]      io_master_arsize,
   output logic [1:0]      io_master_arburst,
   output logic [3:0]      io_master_arid,
   input  logic [XLEN-1:0] io_master_rdata,
   input  logic            io_master_rvalid,
   input  logic            io_master_rlast,
   input  logic [3:0]      io_master_rid,
   input  logic [1:0]      io_master_rresp,
   output logic            io_master_rready,
   output logic            out_rresp_err,
   output logic            out_busy,
   output logic [31:0]     out_perf_ifu_grants,
   output logic [31:0]     out_perf_lsu_grants
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_AR_IFU  = 3'd1,
      S_AR_LSU  = 3'd2,
      S_R_IFU   = 3'd3,
      S_R_LSU   = 3'd4,
      S_R_DRAIN = 3'd5
   } state_t;

   localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);
   localparam logic [3:0] C_ID_IFU     = 4'd0;
   localparam logic [3:0] C_ID_LSU     = 4'd1;

   state_t          state_q, state_d;
   logic [3:0]      starve_q, starve_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [7:0]      len_q, len_d;
   logic [2:0]      size_q, size_d;
   logic            flush_seen_q, flush_seen_d;   // flush hit while AR_LSU pending

   logic w_ifu_req, w_lsu_req, w_grant_ifu, w_grant_lsu;

   // Requests are masked during reset so every output reads 0 while it is held.
   assign w_ifu_req   = ifu_arvalid & ~reset;
   assign w_lsu_req   = lsu_arvalid & ~flush_pipeline & ~reset;
   assign w_grant_lsu = (state_q == S_IDLE) & w_lsu_req &
                        (~w_ifu_req | (starve_q != C_STARVE_MAX));
   assign w_grant_ifu = (state_q == S_IDLE) & w_ifu_req & ~w_grant_lsu;

   always_comb begin
      state_d           = state_q;
      starve_d          = starve_q;
      addr_d            = addr_q;
      len_d             = len_q;
      size_d            = size_q;
      flush_seen_d      = flush_seen_q;
      out_ifu_arready   = 1'b0;
      out_lsu_arready   = 1'b0;
      out_ifu_rdata     = '0;
      out_ifu_rvalid    = 1'b0;
      out_ifu_rlast     = 1'b0;
      out_lsu_rdata     = '0;
      out_lsu_rvalid    = 1'b0;
      io_master_araddr  = '0;
      io_master_arvalid = 1'b0;
      io_master_arlen   = 8'd0;
      io_master_arsize  = 3'd0;
      io_master_arburst = 2'b00;
      io_master_arid    = 4'd0;
      io_master_rready  = 1'b0;
      out_rresp_err     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (w_grant_lsu) begin
               out_lsu_arready = 1'b1;
               addr_d          = lsu_araddr;
               len_d           = 8'd0;
               size_d          = lsu_arsize;
               flush_seen_d    = 1'b0;
               state_d         = S_AR_LSU;
               // Only LSU wins that actually overtook a waiting IFU count.
               if (ifu_arvalid && (starve_q < C_STARVE_MAX))
                  starve_d = starve_q + 4'd1;
            end else if (w_grant_ifu) begin
               out_ifu_arready = 1'b1;
               addr_d          = ifu_araddr;
               len_d           = ifu_arlen;
               size_d          = 3'b010;
               starve_d        = 4'd0;
               state_d         = S_AR_IFU;
            end
         end
         S_AR_IFU: begin
            io_master_arvalid = 1'b1;
            io_master_araddr  = addr_q;
            io_master_arlen   = len_q;
            io_master_arsize  = size_q;
            io_master_arburst = (len_q != 8'd0) ? 2'b01 : 2'b00;
            io_master_arid    = C_ID_IFU;
            if (io_master_arready) state_d = S_R_IFU;
         end
         S_AR_LSU: begin
            io_master_arvalid = 1'b1;
            io_master_araddr  = addr_q;
            io_master_arsize  = size_q;
            io_master_arid    = C_ID_LSU;
            if (flush_pipeline) flush_seen_d = 1'b1;
            // The AR cannot be withdrawn; a killed load is completed then drained.
            if (io_master_arready)
               state_d = (flush_seen_q || flush_pipeline) ? S_R_DRAIN : S_R_LSU;
         end
         S_R_IFU: begin
            io_master_rready = 1'b1;
            out_ifu_rvalid   = io_master_rvalid;
            out_ifu_rdata    = io_master_rdata;
            out_ifu_rlast    = io_master_rlast;
            out_rresp_err    = io_master_rvalid & (io_master_rresp != 2'b00);
            if (io_master_rvalid && io_master_rlast) state_d = S_IDLE;
         end
         S_R_LSU: begin
            io_master_rready = 1'b1;
            out_lsu_rvalid   = io_master_rvalid;
            out_lsu_rdata    = io_master_rdata;
            out_rresp_err    = io_master_rvalid & (io_master_rresp != 2'b00);
            // A beat arriving with the flush still reaches the LSU.
            if (io_master_rvalid)    state_d = S_IDLE;
            else if (flush_pipeline) state_d = S_R_DRAIN;
         end
         S_R_DRAIN: begin
            io_master_rready = 1'b1;
            out_rresp_err    = io_master_rvalid & (io_master_rresp != 2'b00);
            if (io_master_rvalid && io_master_rlast) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign out_busy = (state_q != S_IDLE);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         starve_q     <= 4'd0;
         addr_q       <= '0;
         len_q        <= 8'd0;
         size_q       <= 3'd0;
         flush_seen_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         starve_q     <= starve_d;
         addr_q       <= addr_d;
         len_q        <= len_d;
         size_q       <= size_d;
         flush_seen_q <= flush_seen_d;
      end
   end

   a_rid_ifu: assert property (@(posedge clock) disable iff (reset)
      (state_q == S_R_IFU && io_master_rvalid) |-> (io_master_rid == C_ID_IFU));
   a_rid_lsu: assert property (@(posedge clock) disable iff (reset)
      ((state_q == S_R_LSU || state_q == S_R_DRAIN) && io_master_rvalid)
         |-> (io_master_rid == C_ID_LSU));
   a_rlast_lsu: assert property (@(posedge clock) disable iff (reset)
      (state_q == S_R_LSU && io_master_rvalid) |-> io_master_rlast);

`ifdef YSYX_BUS_RD_ARB_PERF_EN
   logic [31:0] perf_ifu_grants_q, perf_lsu_grants_q, perf_drained_q, perf_ifu_wait_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         perf_ifu_grants_q <= 32'd0;
         perf_lsu_grants_q <= 32'd0;
         perf_drained_q    <= 32'd0;
         perf_ifu_wait_q   <= 32'd0;
      end else begin
         if (out_ifu_arready) perf_ifu_grants_q <= perf_ifu_grants_q + 32'd1;
         if (out_lsu_arready) perf_lsu_grants_q <= perf_lsu_grants_q + 32'd1;
         if (state_q == S_R_DRAIN && io_master_rvalid && io_master_rlast)
            perf_drained_q <= perf_drained_q + 32'd1;
         if (ifu_arvalid && !out_ifu_arready)
            perf_ifu_wait_q <= perf_ifu_wait_q + 32'd1;
      end
   end

   assign out_perf_ifu_grants = perf_ifu_grants_q;
   assign out_perf_lsu_grants = perf_lsu_grants_q;

   final begin
      $display("ysyx_bus_rd_arb perf: ifu_grants=%0d lsu_grants=%0d drained_loads=%0d ifu_wait_cycles=%0d",
               perf_ifu_grants_q, perf_lsu_grants_q, perf_drained_q, perf_ifu_wait_q);
   end
`else
   assign out_perf_ifu_grants = 32'd0;
   assign out_perf_lsu_grants = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx_bus_rd_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_bus_rd_arb
// Purpose  : Self-checking bench for ysyx_bus_rd_arb with an AXI slave model
//            and per-requester response scoreboards.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_bus_rd_arb;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        flush_pipeline = 1'b0;
   logic        ifu_arvalid = 1'b0;
   logic [31:0] ifu_araddr = '0;
   logic [7:0]  ifu_arlen = '0;
   logic        out_ifu_arready;
   logic [31:0] out_ifu_rdata;
   logic        out_ifu_rvalid, out_ifu_rlast;
   logic        lsu_arvalid = 1'b0;
   logic [31:0] lsu_araddr = '0;
   logic [2:0]  lsu_arsize = '0;
   logic        out_lsu_arready;
   logic [31:0] out_lsu_rdata;
   logic        out_lsu_rvalid;
   logic [31:0] io_master_araddr;
   logic        io_master_arvalid;
   logic        io_master_arready;
   logic [7:0]  io_master_arlen;
   logic [2:0]  io_master_arsize;
   logic [1:0]  io_master_arburst;
   logic [3:0]  io_master_arid;
   logic [31:0] io_master_rdata;
   logic        io_master_rvalid, io_master_rlast;
   logic [3:0]  io_master_rid;
   logic [1:0]  io_master_rresp;
   logic        io_master_rready;
   logic        out_rresp_err, out_busy;
   logic [31:0] out_perf_ifu_grants, out_perf_lsu_grants;

   int checks = 0;
   int errors = 0;

   int          ar_wait = 0;
   int          rd_wait = 0;
   logic [1:0]  rresp_v = 2'b00;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } exp_t;
   exp_t ifu_q[$];
   exp_t lsu_q[$];

   ysyx_bus_rd_arb #(.XLEN(32), .STARVE_MAX(4)) dut (
      .clock(clock), .reset(reset), .flush_pipeline(flush_pipeline),
      .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arlen(ifu_arlen),
      .out_ifu_arready(out_ifu_arready), .out_ifu_rdata(out_ifu_rdata),
      .out_ifu_rvalid(out_ifu_rvalid), .out_ifu_rlast(out_ifu_rlast),
      .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize),
      .out_lsu_arready(out_lsu_arready), .out_lsu_rdata(out_lsu_rdata),
      .out_lsu_rvalid(out_lsu_rvalid),
      .io_master_araddr(io_master_araddr), .io_master_arvalid(io_master_arvalid),
      .io_master_arready(io_master_arready), .io_master_arlen(io_master_arlen),
      .io_master_arsize(io_master_arsize), .io_master_arburst(io_master_arburst),
      .io_master_arid(io_master_arid), .io_master_rdata(io_master_rdata),
      .io_master_rvalid(io_master_rvalid), .io_master_rlast(io_master_rlast),
      .io_master_rid(io_master_rid), .io_master_rresp(io_master_rresp),
      .io_master_rready(io_master_rready), .out_rresp_err(out_rresp_err),
      .out_busy(out_busy), .out_perf_ifu_grants(out_perf_ifu_grants),
      .out_perf_lsu_grants(out_perf_lsu_grants)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] exp_data(input logic [31:0] a, input int beat);
      if (a == 32'h3000_0000 && beat == 0) return 32'hDEAD_BEEF;
      return (a ^ 32'h5A5A_5A5A) + 32'(beat);
   endfunction

   // AXI slave model: all decisions at the falling edge, echoing arid on rid.
   initial begin : slave
      int sst, cnt, beat;
      logic [31:0] a;
      logic [7:0]  l;
      logic [3:0]  id;
      sst = 0; cnt = 0; beat = 0; a = '0; l = '0; id = '0;
      io_master_arready = 1'b0; io_master_rvalid = 1'b0; io_master_rlast = 1'b0;
      io_master_rdata = '0; io_master_rid = '0; io_master_rresp = '0;
      forever begin
         @(negedge clock);
         if (reset) begin
            sst = 0; cnt = 0;
            io_master_arready = 1'b0; io_master_rvalid = 1'b0; io_master_rlast = 1'b0;
         end else begin
            case (sst)
               0: begin
                  if (io_master_arvalid) begin
                     if (cnt >= ar_wait) begin
                        io_master_arready = 1'b1;
                        a = io_master_araddr; l = io_master_arlen; id = io_master_arid;
                        sst = 1; cnt = 0; beat = 0;
                     end else cnt++;
                  end else cnt = 0;
               end
               1: begin
                  io_master_arready = 1'b0;
                  if (cnt >= rd_wait) begin
                     io_master_rvalid = 1'b1;
                     io_master_rdata  = exp_data(a, beat);
                     io_master_rlast  = (beat == int'(l));
                     io_master_rid    = id;
                     io_master_rresp  = rresp_v;
                     sst = 2;
                  end else cnt++;
               end
               default: begin
                  beat++;
                  if (beat > int'(l)) begin
                     io_master_rvalid = 1'b0; io_master_rlast = 1'b0;
                     sst = 0; cnt = 0;
                  end else begin
                     io_master_rdata = exp_data(a, beat);
                     io_master_rlast = (beat == int'(l));
                  end
               end
            endcase
         end
      end
   end

   // Response scoreboard: pops an expected beat whenever the DUT forwards one.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clock); #2;
         if (out_ifu_rvalid) begin
            checks++;
            if (ifu_q.size() == 0) begin
               errors++;
               $display("FAIL ifu_unexpected_beat: got rdata %h, required no beat", out_ifu_rdata);
            end else begin
               e = ifu_q.pop_front();
               if ({out_ifu_rdata, out_ifu_rlast} !== {e.data, e.last}) begin
                  errors++;
                  $display("FAIL ifu_beat: got %h/%b required %h/%b",
                           out_ifu_rdata, out_ifu_rlast, e.data, e.last);
               end
            end
         end
         if (out_lsu_rvalid) begin
            checks++;
            if (lsu_q.size() == 0) begin
               errors++;
               $display("FAIL lsu_unexpected_beat: got rdata %h, required no beat", out_lsu_rdata);
            end else begin
               e = lsu_q.pop_front();
               if (out_lsu_rdata !== e.data) begin
                  errors++;
                  $display("FAIL lsu_beat: got %h required %h", out_lsu_rdata, e.data);
               end
            end
         end
      end
   end

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clock); #3;
         if (!out_busy && ifu_q.size() == 0 && lsu_q.size() == 0) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; ifu_arvalid = 1'b1; lsu_arvalid = 1'b1; ifu_araddr = 32'h1234;
      repeat (2) @(negedge clock);
      #1;
      checks++;
      if ({out_busy, io_master_arvalid, io_master_rready, out_ifu_arready, out_lsu_arready,
           io_master_araddr, out_rresp_err} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got busy=%b arvalid=%b rready=%b iar=%b lar=%b, required all 0",
                  out_busy, io_master_arvalid, io_master_rready, out_ifu_arready, out_lsu_arready);
      end
      ifu_arvalid = 1'b0; lsu_arvalid = 1'b0; ifu_araddr = '0;
      @(negedge clock);
      reset = 1'b0;
      #1;
      checks++;
      if (out_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_busy: got %b required 0", out_busy);
      end
   endtask

   task automatic test_ifu_single();
      bit ok;
      @(negedge clock);
      ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0000; ifu_arlen = 8'd0;
      #1;
      checks++;
      if (out_ifu_arready !== 1'b1) begin
         errors++; $display("FAIL ifu_grant: got %b required 1", out_ifu_arready);
      end
      ifu_q.push_back('{data: 32'hDEAD_BEEF, last: 1'b1});
      @(negedge clock);
      ifu_arvalid = 1'b0;
      lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_0100; lsu_arsize = 3'd2;
      #1;
      checks++;
      if ({io_master_arvalid, io_master_araddr, io_master_arid, io_master_arsize,
           io_master_arburst, io_master_arlen} !==
          {1'b1, 32'h3000_0000, 4'd0, 3'd2, 2'b00, 8'd0}) begin
         errors++;
         $display("FAIL ifu_ar_fields: got v=%b a=%h id=%h sz=%h bu=%b len=%h required 1/30000000/0/2/00/00",
                  io_master_arvalid, io_master_araddr, io_master_arid, io_master_arsize,
                  io_master_arburst, io_master_arlen);
      end
      checks++;
      if (out_lsu_arready !== 1'b0) begin
         errors++; $display("FAIL lsu_grant_cycle1: got %b required 0", out_lsu_arready);
      end
      @(negedge clock); #1;
      checks++;
      if (out_lsu_arready !== 1'b0) begin
         errors++; $display("FAIL lsu_grant_cycle2: got %b required 0", out_lsu_arready);
      end
      @(negedge clock); #1;
      checks++;
      if (out_lsu_arready !== 1'b1) begin
         errors++; $display("FAIL lsu_grant_cycle3: got %b required 1", out_lsu_arready);
      end
      lsu_q.push_back('{data: exp_data(32'h8000_0100, 0), last: 1'b1});
      @(negedge clock);
      lsu_arvalid = 1'b0;
      #1;
      checks++;
      if ({io_master_arid, io_master_arsize, io_master_arlen, io_master_arburst} !==
          {4'd1, 3'd2, 8'd0, 2'b00}) begin
         errors++;
         $display("FAIL lsu_ar_fields: got id=%h sz=%h len=%h bu=%b required 1/2/00/00",
                  io_master_arid, io_master_arsize, io_master_arlen, io_master_arburst);
      end
      wait_idle(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL ifu_single_idle: got busy, required idle"); end
   endtask

   task automatic test_starve();
      bit ok;
      bit exp_ifu [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
      int n = 0;
      @(negedge clock);
      ifu_arvalid = 1'b1; ifu_araddr = 32'h0000_1000; ifu_arlen = 8'd0;
      lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_0200; lsu_arsize = 3'd2;
      for (int c = 0; c < 200 && n < 10; c++) begin
         #1;
         if (out_ifu_arready || out_lsu_arready) begin
            checks++;
            if (out_ifu_arready !== exp_ifu[n] || out_lsu_arready === out_ifu_arready) begin
               errors++;
               $display("FAIL starve_order[%0d]: got ifu=%b lsu=%b required ifu=%b",
                        n, out_ifu_arready, out_lsu_arready, exp_ifu[n]);
            end
            if (exp_ifu[n]) ifu_q.push_back('{data: exp_data(32'h0000_1000, 0), last: 1'b1});
            else            lsu_q.push_back('{data: exp_data(32'h8000_0200, 0), last: 1'b1});
            n++;
         end
         @(negedge clock);
      end
      ifu_arvalid = 1'b0; lsu_arvalid = 1'b0;
      checks++;
      if (n != 10) begin errors++; $display("FAIL starve_grants: got %0d grants required 10", n); end
      wait_idle(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL starve_idle: got busy, required idle"); end
   endtask

   task automatic test_flush_drain();
      int ar_cyc = 0;
      bit addr_bad = 0, saw_beat = 0, bad_drain = 0;
      ar_wait = 3;
      @(negedge clock);
      lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_0010; lsu_arsize = 3'd2;
      #1;
      checks++;
      if (out_lsu_arready !== 1'b1) begin
         errors++; $display("FAIL drain_grant: got %b required 1", out_lsu_arready);
      end
      for (int c = 0; c < 12; c++) begin
         @(negedge clock);
         lsu_arvalid = 1'b0;
         flush_pipeline = (c == 0);
         #1;
         if (io_master_arvalid) begin
            ar_cyc++;
            if (io_master_araddr !== 32'h8000_0010) addr_bad = 1;
         end
         if (io_master_rvalid) begin
            saw_beat = 1;
            if (out_lsu_rvalid !== 1'b0 || io_master_rready !== 1'b1 || out_busy !== 1'b1)
               bad_drain = 1;
         end
      end
      ar_wait = 0;
      checks++;
      if (ar_cyc != 4 || addr_bad) begin
         errors++; $display("FAIL drain_ar_hold: got %0d cycles bad_addr=%b required 4/0", ar_cyc, addr_bad);
      end
      checks++;
      if (!saw_beat || bad_drain) begin
         errors++; $display("FAIL drain_beat: got seen=%b bad=%b required 1/0", saw_beat, bad_drain);
      end
      checks++;
      if (out_busy !== 1'b0) begin errors++; $display("FAIL drain_idle: got busy=%b required 0", out_busy); end
   endtask

   task automatic test_ifu_burst();
      bit ok;
      int beats = 0;
      @(negedge clock);
      ifu_arvalid = 1'b1; ifu_araddr = 32'hA000_0000; ifu_arlen = 8'd1;
      #1;
      checks++;
      if (out_ifu_arready !== 1'b1) begin
         errors++; $display("FAIL burst_grant: got %b required 1", out_ifu_arready);
      end
      ifu_q.push_back('{data: exp_data(32'hA000_0000, 0), last: 1'b0});
      ifu_q.push_back('{data: exp_data(32'hA000_0000, 1), last: 1'b1});
      @(negedge clock);
      ifu_arvalid = 1'b0;
      #1;
      checks++;
      if ({io_master_arburst, io_master_arlen, io_master_arsize, io_master_arid} !==
          {2'b01, 8'd1, 3'd2, 4'd0}) begin
         errors++;
         $display("FAIL burst_ar_fields: got bu=%b len=%h sz=%h id=%h required 01/01/2/0",
                  io_master_arburst, io_master_arlen, io_master_arsize, io_master_arid);
      end
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         flush_pipeline = 1'b1;
         #3;
         if (out_ifu_rvalid) beats++;
      end
      flush_pipeline = 1'b0;
      wait_idle(ok);
      checks++;
      if (beats != 2 || !ok) begin
         errors++; $display("FAIL burst_beats: got %0d beats idle=%b required 2/1", beats, ok);
      end
   endtask

   task automatic test_rresp_err();
      bit ok;
      int pulses = 0;
      bit mism = 0;
      rresp_v = 2'b10;
      @(negedge clock);
      lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_0020; lsu_arsize = 3'd2;
      #1;
      checks++;
      if (out_lsu_arready !== 1'b1) begin
         errors++; $display("FAIL rresp_grant: got %b required 1", out_lsu_arready);
      end
      lsu_q.push_back('{data: exp_data(32'h8000_0020, 0), last: 1'b1});
      for (int c = 0; c < 8; c++) begin
         @(negedge clock);
         lsu_arvalid = 1'b0;
         #3;
         if (out_rresp_err) begin
            pulses++;
            if (!out_lsu_rvalid) mism = 1;
         end
      end
      rresp_v = 2'b00;
      checks++;
      if (pulses != 1 || mism) begin
         errors++; $display("FAIL rresp_err_pulse: got %0d pulses mism=%b required 1/0", pulses, mism);
      end
      wait_idle(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rresp_idle: got busy, required idle"); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      rd_wait = 5;
      @(negedge clock);
      ifu_arvalid = 1'b1; ifu_araddr = 32'h0000_0040; ifu_arlen = 8'd0;
      #1;
      checks++;
      if (out_ifu_arready !== 1'b1) begin
         errors++; $display("FAIL rstmid_grant: got %b required 1", out_ifu_arready);
      end
      @(negedge clock);
      ifu_arvalid = 1'b0;
      @(negedge clock);
      #1;
      checks++;
      if ({out_busy, io_master_rready} !== 2'b11) begin
         errors++; $display("FAIL rstmid_in_r: got busy=%b rready=%b required 1/1", out_busy, io_master_rready);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({out_busy, io_master_rready, io_master_arvalid, io_master_araddr, out_ifu_rvalid,
           out_ifu_rdata, out_ifu_rlast, out_lsu_rvalid, out_rresp_err} !== '0) begin
         errors++;
         $display("FAIL rstmid_outputs: got busy=%b rready=%b arvalid=%b required all 0",
                  out_busy, io_master_rready, io_master_arvalid);
      end
      rd_wait = 0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_0030; lsu_arsize = 3'd1;
      #1;
      checks++;
      if (out_lsu_arready !== 1'b1) begin
         errors++; $display("FAIL rstmid_lsu_grant: got %b required 1", out_lsu_arready);
      end
      lsu_q.push_back('{data: exp_data(32'h8000_0030, 0), last: 1'b1});
      @(negedge clock);
      lsu_arvalid = 1'b0;
      wait_idle(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rstmid_idle: got busy, required idle"); end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no completion, required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      test_reset();
      test_ifu_single();
      test_starve();
      test_flush_drain();
      test_ifu_burst();
      test_rresp_err();
      test_reset_mid();
      repeat (2) @(negedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
